// File: rtl/axi_common_types_pkg.sv
// Shared AXI4 widths, response/burst encodings and the burst-engine state set.
// Imported by the AXI master and slave agents on the NoC.
package axi_common_types_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 4;
    localparam int AXI_USER_WIDTH = 1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA
    } burst_state_e;

    // Encodings are ordered by severity, so the numeric maximum is the worst response.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_m_burst_initiator.sv
// AXI4 master engine: runs one AW/W/B or AR/R burst per command and reports
// a single completion with the worst response seen.
module axi_m_burst_initiator
    import axi_common_types_pkg::*;
#(
    parameter int ID_W   = AXI_ID_WIDTH,
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int LEN_W  = AXI_LEN_WIDTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ID_W-1:0]           cmd_id,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_W-1:0]         wd_data,
    input  logic [DATA_W/8-1:0]       wd_strb,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [1:0]                rd_resp,
    output logic                      rd_last,
    output logic                      done_valid,
    output logic [ID_W-1:0]           done_id,
    output logic [1:0]                done_resp,
    output logic                      proto_err,
    output logic [ID_W-1:0]           M_AWID,
    output logic [ADDR_W-1:0]         M_AWADDR,
    output logic [LEN_W-1:0]          M_AWLEN,
    output logic [2:0]                M_AWSIZE,
    output logic [1:0]                M_AWBURST,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic                      M_AWLOCK,
    output logic [3:0]                M_AWCACHE,
    output logic [2:0]                M_AWPROT,
    output logic [3:0]                M_AWQOS,
    output logic [3:0]                M_AWREGION,
    output logic [AXI_USER_WIDTH-1:0] M_AWUSER,
    output logic [DATA_W-1:0]         M_WDATA,
    output logic [DATA_W/8-1:0]       M_WSTRB,
    output logic                      M_WLAST,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    output logic [AXI_USER_WIDTH-1:0] M_WUSER,
    input  logic [ID_W-1:0]           M_BID,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ID_W-1:0]           M_ARID,
    output logic [ADDR_W-1:0]         M_ARADDR,
    output logic [LEN_W-1:0]          M_ARLEN,
    output logic [2:0]                M_ARSIZE,
    output logic [1:0]                M_ARBURST,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    output logic                      M_ARLOCK,
    output logic [3:0]                M_ARCACHE,
    output logic [2:0]                M_ARPROT,
    output logic [3:0]                M_ARQOS,
    output logic [3:0]                M_ARREGION,
    output logic [AXI_USER_WIDTH-1:0] M_ARUSER,
    input  logic [ID_W-1:0]           M_RID,
    input  logic [DATA_W-1:0]         M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RLAST,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    burst_state_e       state;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [LEN_W-1:0]   cnt;
    logic [1:0]         worst;
    logic               overrun;
    logic               awvalid_q;
    logic               arvalid_q;
    logic               bready_q;

    logic               in_wdata;
    logic               in_rdata;
    logic               w_hs;
    logic               r_hs;
    logic               at_last;
    logic [1:0]         r_worst;

    assign in_wdata = (state == WDATA);
    assign in_rdata = (state == RDATA);
    assign at_last  = (cnt == len_q);
    assign w_hs     = in_wdata & wd_valid & M_WREADY;
    assign r_hs     = in_rdata & M_RVALID & rd_ready;
    assign r_worst  = resp_max(worst, M_RRESP);

    assign M_AWID    = id_q;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = len_q;
    assign M_AWSIZE  = size_q;
    assign M_AWBURST = burst_q;
    assign M_AWVALID = awvalid_q;
    assign M_ARID    = id_q;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = size_q;
    assign M_ARBURST = burst_q;
    assign M_ARVALID = arvalid_q;
    assign M_BREADY  = bready_q;

    // W and R pass straight through while their state is active; forced low otherwise.
    assign M_WVALID = in_wdata & wd_valid;
    assign M_WDATA  = in_wdata ? wd_data : '0;
    assign M_WSTRB  = in_wdata ? wd_strb : '0;
    assign M_WLAST  = in_wdata & at_last;
    assign wd_ready = in_wdata & M_WREADY;

    assign rd_valid = in_rdata & M_RVALID;
    assign rd_data  = in_rdata ? M_RDATA : '0;
    assign rd_resp  = in_rdata ? M_RRESP : 2'b00;
    assign rd_last  = in_rdata & M_RLAST;
    assign M_RREADY = in_rdata & rd_ready;

    assign M_AWLOCK   = 1'b0;
    assign M_AWCACHE  = '0;
    assign M_AWPROT   = '0;
    assign M_AWQOS    = '0;
    assign M_AWREGION = '0;
    assign M_AWUSER   = '0;
    assign M_WUSER    = '0;
    assign M_ARLOCK   = 1'b0;
    assign M_ARCACHE  = '0;
    assign M_ARPROT   = '0;
    assign M_ARQOS    = '0;
    assign M_ARREGION = '0;
    assign M_ARUSER   = '0;

    logic unused_resp_ids;
    assign unused_resp_ids = ^{M_BID, M_RID};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cnt        <= '0;
            worst      <= RESP_OKAY;
            overrun    <= 1'b0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            cmd_ready  <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_resp  <= RESP_OKAY;
            proto_err  <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            proto_err  <= 1'b0;
            case (state)
                // cmd_ready rises one cycle after IDLE is entered, whether from reset or a completion.
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        size_q    <= cmd_size;
                        burst_q   <= cmd_burst;
                        cnt       <= '0;
                        worst     <= RESP_OKAY;
                        overrun   <= 1'b0;
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state     <= WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WADDR: begin
                    if (M_AWREADY) begin
                        awvalid_q <= 1'b0;
                        state     <= WDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        cnt <= cnt + LEN_W'(1);
                        if (at_last) begin
                            bready_q <= 1'b1;
                            state    <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (M_BVALID) begin
                        bready_q   <= 1'b0;
                        done_valid <= 1'b1;
                        done_id    <= id_q;
                        done_resp  <= M_BRESP;
                        state      <= IDLE;
                    end
                end
                RADDR: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state     <= RDATA;
                    end
                end
                // overrun marks a missing RLAST on beat len; later beats are drained without re-flagging.
                RDATA: begin
                    if (r_hs) begin
                        cnt   <= cnt + LEN_W'(1);
                        worst <= r_worst;
                        if (M_RLAST) begin
                            done_valid <= 1'b1;
                            done_id    <= id_q;
                            state      <= IDLE;
                            if (overrun || !at_last) begin
                                done_resp <= resp_max(r_worst, RESP_SLVERR);
                                proto_err <= ~overrun;
                            end else begin
                                done_resp <= r_worst;
                            end
                        end else if (at_last && !overrun) begin
                            overrun   <= 1'b1;
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_m_burst_initiator.md
# axi_m_burst_initiator

Synthesizable AXI4 master engine that issues one burst at a time toward the NoC slave ports. It is the initiating end of the same channel set the slave-side agents (S0..S6) respond to. Upstream logic supplies a command, write beats, or a read-data sink; the block sequences the AW/W/B or AR/R handshakes and reports a single completion per command.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width (STRB width = DATA_W/8)
- LEN_W, 4, burst length field (beats = len+1, 1..16)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst  in  ID_W / ADDR_W / LEN_W / 3 / 2  burst attributes
- wd_valid / wd_ready  in / out  1  write-beat handshake
- wd_data, wd_strb  in  DATA_W / DATA_W/8  write beat
- rd_valid / rd_ready  out / in  1  read-beat handshake
- rd_data, rd_resp, rd_last  out  DATA_W / 2 / 1  read beat
- done_valid  out  1  one-cycle completion pulse
- done_id, done_resp  out  ID_W / 2  completed ID and worst response
- proto_err  out  1  one-cycle pulse on RLAST mismatch
- M_AW{ID,ADDR,LEN,SIZE,BURST,VALID}, M_AWREADY  out / in  AW channel
- M_W{DATA,STRB,LAST,VALID}, M_WREADY  out / in  W channel
- M_B{ID,RESP,VALID}, M_BREADY  in / out  B channel
- M_AR{ID,ADDR,LEN,SIZE,BURST,VALID}, M_ARREADY  out / in  AR channel
- M_R{ID,DATA,RESP,LAST,VALID}, M_RREADY  in / out  R channel
- M_{AW,AR}{LOCK,CACHE,PROT,QOS,REGION,USER}, M_{W}USER  out  tied to 0

## Operation
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: cmd_ready=1. On cmd_valid, latch attributes, clear beat counter and worst-response register, go to WADDR (write) or RADDR (read).
- WADDR: AWVALID=1 from registered attributes, held stable until AWREADY. Then go to WDATA.
- WDATA: M_WVALID=wd_valid, wd_ready=M_WREADY, data passes through. WLAST=(cnt==len). Each W handshake increments cnt. Handshake with WLAST goes to WRESP.
- WRESP: BREADY=1. On BVALID, done_valid pulses with done_resp=BRESP and done_id=latched id, then go to IDLE. BID is not checked.
- RADDR: ARVALID=1, held until ARREADY, then go to RDATA.
- RDATA: rd_* mirror M_R*. M_RREADY=rd_ready. Each beat updates worst = max(worst, RRESP) using encoding order DECERR>SLVERR>EXOKAY>OKAY. Terminates on RLAST handshake.
- RLAST check:
  - RLAST with cnt!=len: proto_err pulses and done_resp=SLVERR.
  - No RLAST on beat len: proto_err pulses and done_resp=SLVERR, but the block keeps accepting beats until RLAST.
- Only one outstanding transaction; cmd_ready=0 outside IDLE.

## Timing
- All outputs are 0 in reset, including every VALID and READY, cmd_ready, done_valid and proto_err.
- cmd handshake at edge N: AWVALID/ARVALID is high from cycle N+1.
- No VALID depends combinationally on the same channel's READY.
- W and R are combinational pass-through, so there are no bubbles beyond slave/upstream stalls.
- done_valid is asserted the cycle after the final B/R handshake, and IDLE is re-entered that same cycle.
- A new command is accepted at the earliest one cycle after done_valid.
- Asynchronous reset mid-burst: FSM goes to IDLE and all VALIDs drop immediately. No completion is reported.

## Structure
- Response encodings, FSM state enum and the max-response function belong in axi_common_types_pkg; widths come from the existing AXI_*_WIDTH constants.
- Single module, no submodules. The beat counter is inline.

## Test plan
- Write id=3, addr=0x1000, len=3, size=2, INCR, slave ready always, BRESP=OKAY: 4 W beats with WLAST on beat 4, done_valid=1 with id=3 and resp=00.
- Read len=0 with ARREADY delayed 5 cycles: ARVALID held stable 6 cycles, 1 rd beat with rd_last=1, done_resp=00.
- Read len=7 with RRESP=SLVERR on beat 2 only, rd_ready toggling: 8 beats delivered in order, done_resp=10.
- Read len=3 with RLAST on beat 2: proto_err pulses, done_resp=10, FSM returns to IDLE.
- ARESETn asserted during WDATA beat 2: WVALID and AWVALID are 0 immediately, cmd_ready=1 after release, and a following write completes normally.
- Back-to-back write then read commands: the second cmd_ready goes high exactly one cycle after the first done_valid.
